// File: rtl/ip_stack_serial_if.sv
// Host-side bundle for the serial instruction-pointer stack: fetch/command
// strobes in, nibble bus and stack status out.
interface ip_stack_serial_if #(
  parameter int NIBBLES = 3,
  parameter int DEPTH   = 4
);
  localparam int AW  = 4 * NIBBLES;
  localparam int SPW = $clog2(DEPTH);

  logic           fetch_start;
  logic           cmd_valid;
  logic [1:0]     cmd;
  logic [AW-1:0]  cmd_addr;
  logic [3:0]     dout;
  logic           dout_en;
  logic           busy;
  logic [AW-1:0]  pc;
  logic [SPW-1:0] sp;
  logic           ovf;
  logic           unf;

  modport master (
    output fetch_start, cmd_valid, cmd, cmd_addr,
    input  dout, dout_en, busy, pc, sp, ovf, unf
  );

  modport slave (
    input  fetch_start, cmd_valid, cmd, cmd_addr,
    output dout, dout_en, busy, pc, sp, ovf, unf
  );
endinterface

// File: rtl/ip_stack_serial.sv
// Program counter plus return stack; the PC is streamed low nibble first and
// incremented one nibble per cycle with a registered carry.
module ip_stack_serial #(
  parameter int NIBBLES = 3,
  parameter int DEPTH   = 4,
  parameter int WRAP    = 1
) (
  input logic               sysclk,
  input logic               poc_n,
  ip_stack_serial_if.slave  bus
);
  localparam int AW  = 4 * NIBBLES;
  localparam int SPW = $clog2(DEPTH);
  localparam int IW  = 3;
  localparam logic [SPW-1:0] SP_MAX   = SPW'(DEPTH - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(NIBBLES - 1);

  localparam logic [1:0] CMD_JUMP = 2'd0;
  localparam logic [1:0] CMD_CALL = 2'd1;
  localparam logic [1:0] CMD_RET  = 2'd2;
  localparam logic [1:0] CMD_PAGE = 2'd3;

  logic [AW-1:0]  rows [DEPTH];
  logic [SPW-1:0] sp_q;
  logic [SPW-1:0] depth_count;
  logic [SPW-1:0] sp_inc;
  logic [SPW-1:0] sp_dec;
  logic           busy_q;
  logic           carry;
  logic           ovf_q;
  logic           unf_q;
  logic [IW-1:0]  idx;
  logic [AW-1:0]  top;
  logic [AW-1:0]  next_top;
  logic [3:0]     cur_nib;
  logic [4:0]     nib_sum;
  logic           stack_full;

  // Constant-index nibble select keeps the part-selects width-exact for any NIBBLES.
  always_comb begin
    top      = rows[sp_q];
    cur_nib  = 4'h0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (idx == IW'(k)) cur_nib = top[4*k +: 4];
    end
    nib_sum  = {1'b0, cur_nib} + {4'b0000, carry};
    next_top = top;
    for (int k = 0; k < NIBBLES; k++) begin
      if (idx == IW'(k)) next_top[4*k +: 4] = nib_sum[3:0];
    end
    sp_inc     = sp_q + 1'b1;
    sp_dec     = sp_q - 1'b1;
    stack_full = (depth_count == SP_MAX);
  end

  always_ff @(posedge sysclk) begin
    if (!poc_n) begin
      for (int r = 0; r < DEPTH; r++) rows[r] <= '0;
      sp_q        <= '0;
      depth_count <= '0;
      busy_q      <= 1'b0;
      idx         <= '0;
      carry       <= 1'b1;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else if (busy_q) begin
      rows[sp_q] <= next_top;
      carry      <= nib_sum[4];
      if (idx == IDX_LAST) begin
        busy_q <= 1'b0;
        idx    <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end else if (bus.fetch_start) begin
      busy_q <= 1'b1;
      idx    <= '0;
      carry  <= 1'b1;
    end else if (bus.cmd_valid) begin
      case (bus.cmd)
        CMD_JUMP: rows[sp_q] <= bus.cmd_addr;
        // A full stack only advances when wrapping; the oldest row is then lost.
        CMD_CALL: begin
          if (!stack_full || WRAP != 0) begin
            sp_q         <= sp_inc;
            rows[sp_inc] <= bus.cmd_addr;
            if (!stack_full) depth_count <= depth_count + 1'b1;
          end else begin
            ovf_q <= 1'b1;
          end
        end
        CMD_RET: begin
          if (depth_count != '0) begin
            sp_q        <= sp_dec;
            depth_count <= depth_count - 1'b1;
          end else if (WRAP != 0) begin
            sp_q <= sp_dec;
          end else begin
            unf_q <= 1'b1;
          end
        end
        CMD_PAGE: rows[sp_q][7:0] <= bus.cmd_addr[7:0];
        default: ;
      endcase
    end
  end

  assign bus.dout    = busy_q ? cur_nib : 4'h0;
  assign bus.dout_en = busy_q;
  assign bus.busy    = busy_q;
  assign bus.pc      = top;
  assign bus.sp      = sp_q;
  assign bus.ovf     = ovf_q;
  assign bus.unf     = unf_q;
endmodule

// File: tb/tb_ip_stack_serial.sv
// Directed bench for ip_stack_serial: one saturating (WRAP=0) and one
// circular (WRAP=1) instance, fetch nibbles checked against a scoreboard queue.
module tb_ip_stack_serial;
  localparam int NIBBLES = 3;
  localparam int DEPTH   = 4;

  logic sysclk = 1'b0;
  logic poc_n  = 1'b0;

  ip_stack_serial_if #(.NIBBLES(NIBBLES), .DEPTH(DEPTH)) bus0 ();
  ip_stack_serial_if #(.NIBBLES(NIBBLES), .DEPTH(DEPTH)) bus1 ();

  ip_stack_serial #(.NIBBLES(NIBBLES), .DEPTH(DEPTH), .WRAP(0)) dut0 (
    .sysclk (sysclk),
    .poc_n  (poc_n),
    .bus    (bus0)
  );

  ip_stack_serial #(.NIBBLES(NIBBLES), .DEPTH(DEPTH), .WRAP(1)) dut1 (
    .sysclk (sysclk),
    .poc_n  (poc_n),
    .bus    (bus1)
  );

  always #5 sysclk = ~sysclk;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] exp_q [$];

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input int which, input logic fs, input logic cv,
                                input logic [1:0] c, input logic [11:0] a);
    bus0.fetch_start = (which == 0) ? fs : 1'b0;
    bus0.cmd_valid   = (which == 0) ? cv : 1'b0;
    bus0.cmd         = (which == 0) ? c  : 2'd0;
    bus0.cmd_addr    = (which == 0) ? a  : 12'h000;
    bus1.fetch_start = (which == 1) ? fs : 1'b0;
    bus1.cmd_valid   = (which == 1) ? cv : 1'b0;
    bus1.cmd         = (which == 1) ? c  : 2'd0;
    bus1.cmd_addr    = (which == 1) ? a  : 12'h000;
  endtask

  function automatic logic [11:0] get_pc(input int which);
    return (which == 0) ? bus0.pc : bus1.pc;
  endfunction

  function automatic logic [1:0] get_sp(input int which);
    return (which == 0) ? bus0.sp : bus1.sp;
  endfunction

  task automatic send_cmd(input int which, input logic [1:0] c, input logic [11:0] a);
    apply_stimulus(which, 1'b0, 1'b1, c, a);
    @(negedge sysclk);
    apply_stimulus(which, 1'b0, 1'b0, 2'd0, 12'h000);
  endtask

  task automatic check_state(input int which, input string tag,
                             input logic [11:0] exp_pc, input logic [1:0] exp_sp);
    check_output({tag, "_pc"}, 32'(get_pc(which)), 32'(exp_pc));
    check_output({tag, "_sp"}, 32'(get_sp(which)), 32'(exp_sp));
  endtask

  // page_probe holds a PAGE 0xAB strobe alongside fetch_start and into the busy window.
  task automatic run_fetch(input int which, input logic [11:0] start_pc, input logic page_probe);
    int          busy_cycles;
    logic        cur_busy;
    logic        cur_en;
    logic [3:0]  cur_dout;
    logic [11:0] next_pc;
    next_pc     = start_pc + 12'd1;
    busy_cycles = 0;
    for (int k = 0; k < NIBBLES; k++) exp_q.push_back(start_pc[4*k +: 4]);
    apply_stimulus(which, 1'b1, page_probe, 2'd3, 12'h0AB);
    @(negedge sysclk);
    apply_stimulus(which, 1'b0, page_probe, 2'd3, 12'h0AB);
    for (int n = 0; n < 8; n++) begin
      cur_busy = (which == 0) ? bus0.busy    : bus1.busy;
      cur_en   = (which == 0) ? bus0.dout_en : bus1.dout_en;
      cur_dout = (which == 0) ? bus0.dout    : bus1.dout;
      if (exp_q.size() == 0 && !cur_busy) break;
      if (cur_busy) busy_cycles++;
      if (cur_en && exp_q.size() != 0) check_output("fetch_nibble", 32'(cur_dout), 32'(exp_q.pop_front()));
      @(negedge sysclk);
      if (n == 1) apply_stimulus(which, 1'b0, 1'b0, 2'd0, 12'h000);
    end
    apply_stimulus(which, 1'b0, 1'b0, 2'd0, 12'h000);
    if (exp_q.size() != 0) begin
      check_output("fetch_timeout_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    check_output("fetch_busy_cycles", 32'(busy_cycles), 32'(NIBBLES));
    check_output("fetch_busy_end", 32'((which == 0) ? bus0.busy : bus1.busy), 32'd0);
    check_output("fetch_pc", 32'(get_pc(which)), 32'(next_pc));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    apply_stimulus(0, 1'b0, 1'b0, 2'd0, 12'h000);
    poc_n = 1'b0;
    repeat (2) @(negedge sysclk);
    check_state(0, "reset", 12'h000, 2'd0);
    check_output("reset_busy",    32'(bus0.busy),    32'd0);
    check_output("reset_dout_en", 32'(bus0.dout_en), 32'd0);
    check_output("reset_dout",    32'(bus0.dout),    32'd0);
    check_output("reset_ovf",     32'(bus0.ovf),     32'd0);
    check_output("reset_unf",     32'(bus0.unf),     32'd0);
    poc_n = 1'b1;
    @(negedge sysclk);

    $display("[TB] underflow on empty saturating stack");
    send_cmd(0, 2'd2, 12'h000);
    check_state(0, "ret_empty", 12'h000, 2'd0);
    check_output("ret_empty_unf", 32'(bus0.unf), 32'd1);

    $display("[TB] fetch and carry ripple");
    run_fetch(0, 12'h000, 1'b0);
    send_cmd(0, 2'd0, 12'h0FF);
    run_fetch(0, 12'h0FF, 1'b0);
    send_cmd(0, 2'd0, 12'hFFF);
    run_fetch(0, 12'hFFF, 1'b0);
    check_output("wrap_pc_ovf", 32'(bus0.ovf), 32'd0);

    $display("[TB] call and return");
    send_cmd(0, 2'd0, 12'h123);
    run_fetch(0, 12'h123, 1'b0);
    send_cmd(0, 2'd1, 12'h456);
    check_state(0, "call", 12'h456, 2'd1);
    send_cmd(0, 2'd2, 12'h000);
    check_state(0, "ret", 12'h124, 2'd0);

    $display("[TB] overflow on saturating stack");
    send_cmd(0, 2'd1, 12'h111);
    send_cmd(0, 2'd1, 12'h222);
    send_cmd(0, 2'd1, 12'h333);
    check_state(0, "call3", 12'h333, 2'd3);
    check_output("call3_ovf", 32'(bus0.ovf), 32'd0);
    send_cmd(0, 2'd1, 12'h444);
    check_state(0, "call4", 12'h333, 2'd3);
    check_output("call4_ovf", 32'(bus0.ovf), 32'd1);
    send_cmd(0, 2'd2, 12'h000);
    check_state(0, "unwind1", 12'h222, 2'd2);
    send_cmd(0, 2'd2, 12'h000);
    check_state(0, "unwind2", 12'h111, 2'd1);
    send_cmd(0, 2'd2, 12'h000);
    check_state(0, "unwind3", 12'h124, 2'd0);

    $display("[TB] circular stack");
    send_cmd(1, 2'd1, 12'h010);
    send_cmd(1, 2'd1, 12'h020);
    send_cmd(1, 2'd1, 12'h030);
    send_cmd(1, 2'd1, 12'h040);
    check_state(1, "wrap_call4", 12'h040, 2'd0);
    check_output("wrap_call4_ovf", 32'(bus1.ovf), 32'd0);
    send_cmd(1, 2'd2, 12'h000);
    check_state(1, "wrap_ret", 12'h030, 2'd3);
    check_output("wrap_ret_unf", 32'(bus1.unf), 32'd0);

    $display("[TB] page load dropped while busy, then accepted");
    send_cmd(0, 2'd0, 12'h3FE);
    run_fetch(0, 12'h3FE, 1'b1);
    send_cmd(0, 2'd3, 12'h0AB);
    check_state(0, "page", 12'h3AB, 2'd0);

    $display("[TB] reset mid-fetch");
    apply_stimulus(0, 1'b1, 1'b0, 2'd0, 12'h000);
    @(negedge sysclk);
    apply_stimulus(0, 1'b0, 1'b0, 2'd0, 12'h000);
    check_output("midfetch_busy", 32'(bus0.busy), 32'd1);
    poc_n = 1'b0;
    @(negedge sysclk);
    check_output("midreset_dout_en", 32'(bus0.dout_en), 32'd0);
    check_output("midreset_dout",    32'(bus0.dout),    32'd0);
    check_output("midreset_busy",    32'(bus0.busy),    32'd0);
    check_output("midreset_ovf",     32'(bus0.ovf),     32'd0);
    check_output("midreset_unf",     32'(bus0.unf),     32'd0);
    check_state(0, "midreset", 12'h000, 2'd0);
    check_state(1, "midreset_wrap", 12'h000, 2'd0);
    poc_n = 1'b1;
    @(negedge sysclk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
